seq_ctrl: RTL and testbench

Instruction sequencer for the 8-bit computer. It fetches instructions over a req/ack handshake, decodes the 2-bit opcode class, and drives register-file, ALU, I/O-port and program-counter control for one execute cycle per instruction. It sits between instruction memory and the datapath, replacing a free-running cycle counter with a handshake-aware FSM that detects fetch timeouts.

---
 rtl/seq_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_seq_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seq_ctrl.sv
// Instruction sequencer: req/ack fetch with timeout, decode of the 2-bit class, one-cycle execute.
// Define SEQ_SINGLE_STEP_EN to add a 'step' input that holds after each execute until a rising edge.
module seq_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [7:0]        imem_data,
  input  logic              cond_true,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [2:0]        alu_mode,
  output logic [2:0]        rf_raddr,
  output logic [2:0]        rf_waddr,
  output logic              rf_we,
  output logic [1:0]        wsel,
  output logic [5:0]        imm,
  output logic              iport_re,
  output logic              oport_we,
  output logic [1:0]        state,
  output logic              fault
);

  typedef enum logic [1:0] {FETCH = 2'd0, DECODE = 2'd1, EXEC = 2'd2, FAULT = 2'd3} state_e;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        instr_q, cnt_q;
  logic              req_q, fault_q;
  logic [2:0]        alu_q, raddr_q, waddr_q;
  logic [1:0]        wsel_q;
  logic [5:0]        imm_q;
  logic              we_q, ire_q, owe_q;
  logic [2:0]        alu_d, raddr_d, waddr_d;
  logic [1:0]        wsel_d;
  logic [5:0]        imm_d;
  logic              we_d, ire_d, owe_d;
`ifdef SEQ_SINGLE_STEP_EN
  logic              hold_q, step_q;
`endif

  // Index 6 addresses the I/O port and index 7 is reserved, which turns a COPY into a NOP.
  always_comb begin
    alu_d   = 3'd0;
    raddr_d = 3'd0;
    waddr_d = 3'd0;
    wsel_d  = 2'd0;
    imm_d   = 6'd0;
    we_d    = 1'b0;
    ire_d   = 1'b0;
    owe_d   = 1'b0;
    case (instr_q[7:6])
      2'b00: begin
        we_d  = 1'b1;
        imm_d = instr_q[5:0];
      end
      2'b01: begin
        we_d    = 1'b1;
        waddr_d = 3'd3;
        wsel_d  = 2'd1;
        alu_d   = instr_q[2:0];
      end
      2'b10: begin
        if (instr_q[5:3] != 3'd7 && instr_q[2:0] != 3'd7) begin
          if (instr_q[5:3] == 3'd6) begin
            ire_d  = 1'b1;
            wsel_d = 2'd3;
          end else begin
            raddr_d = instr_q[5:3];
            wsel_d  = 2'd2;
          end
          if (instr_q[2:0] == 3'd6) begin
            owe_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            waddr_d = instr_q[2:0];
          end
        end
      end
      default: ;
    endcase
    pc_d = (instr_q[7:6] == 2'b11 && cond_true) ? jump_target : pc_q + ADDR_W'(1);
  end

  // Decoded fields are loaded in DECODE and cleared every other cycle, so they pulse only in EXEC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= '0;
      instr_q <= 8'd0;
      cnt_q   <= 8'd0;
      req_q   <= 1'b0;
      fault_q <= 1'b0;
      alu_q   <= 3'd0;
      raddr_q <= 3'd0;
      waddr_q <= 3'd0;
      wsel_q  <= 2'd0;
      imm_q   <= 6'd0;
      we_q    <= 1'b0;
      ire_q   <= 1'b0;
      owe_q   <= 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
      hold_q  <= 1'b0;
      step_q  <= 1'b0;
`endif
    end else begin
      alu_q   <= 3'd0;
      raddr_q <= 3'd0;
      waddr_q <= 3'd0;
      wsel_q  <= 2'd0;
      imm_q   <= 6'd0;
      we_q    <= 1'b0;
      ire_q   <= 1'b0;
      owe_q   <= 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
      step_q  <= step;
`endif
      case (state_q)
        FETCH: begin
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (imem_ack) begin
            instr_q <= imem_data;
            req_q   <= 1'b0;
            cnt_q   <= 8'd0;
            state_q <= DECODE;
          end else if (cnt_q + 8'd1 == TimeoutCnt) begin
            req_q   <= 1'b0;
            cnt_q   <= 8'd0;
            fault_q <= 1'b1;
            state_q <= FAULT;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DECODE: begin
          alu_q   <= alu_d;
          raddr_q <= raddr_d;
          waddr_q <= waddr_d;
          wsel_q  <= wsel_d;
          imm_q   <= imm_d;
          we_q    <= we_d;
          ire_q   <= ire_d;
          owe_q   <= owe_d;
          state_q <= EXEC;
        end
        EXEC: begin
`ifdef SEQ_SINGLE_STEP_EN
          // Only a rising edge seen while holding releases the sequencer.
          if (!hold_q) begin
            pc_q   <= pc_d;
            hold_q <= 1'b1;
          end else if (step && !step_q) begin
            hold_q  <= 1'b0;
            req_q   <= 1'b1;
            state_q <= FETCH;
          end
`else
          pc_q    <= pc_d;
          req_q   <= 1'b1;
          state_q <= FETCH;
`endif
        end
        FAULT: begin
          fault_q <= 1'b1;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign alu_mode  = alu_q;
  assign rf_raddr  = raddr_q;
  assign rf_waddr  = waddr_q;
  assign rf_we     = we_q;
  assign wsel      = wsel_q;
  assign imm       = imm_q;
  assign iport_re  = ire_q;
  assign oport_we  = owe_q;
  assign state     = state_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// Scoreboard bench for seq_ctrl: the driver plays instruction memory and queues expected
// execute-cycle outputs; a monitor pops and compares them whenever the DUT is in EXEC.
module tb_seq_ctrl;

  typedef struct packed {
    logic       we;
    logic [2:0] waddr;
    logic [2:0] raddr;
    logic [1:0] wsel;
    logic [5:0] imm;
    logic [2:0] alu;
    logic       ire;
    logic       owe;
  } expT;

  logic       clk = 1'b0;
  logic       reset;
  logic       imemReq;
  logic [7:0] imemAddr;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic       condTrue;
  logic [7:0] jumpTarget;
  logic [2:0] aluMode, rfRaddr, rfWaddr;
  logic       rfWe, iportRe, oportWe, fault;
  logic [1:0] wsel, state;
  logic [5:0] imm;

  int  totalChecks = 0;
  int  passChecks  = 0;
  int  strayStrobes = 0;
  expT expQ[$];

  seq_ctrl #(.ADDR_W(8), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imemReq), .imem_addr(imemAddr), .imem_ack(imem_ack), .imem_data(imem_data),
    .cond_true(condTrue), .jump_target(jumpTarget),
    .alu_mode(aluMode), .rf_raddr(rfRaddr), .rf_waddr(rfWaddr), .rf_we(rfWe),
    .wsel(wsel), .imm(imm), .iport_re(iportRe), .oport_we(oportWe),
    .state(state), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalChecks++;
    if (act === exp) passChecks++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic expT mkExp(input logic we, input logic [2:0] waddr, input logic [2:0] raddr,
                                input logic [1:0] ws, input logic [5:0] im, input logic [2:0] alu,
                                input logic ire, input logic owe);
    mkExp = '{we, waddr, raddr, ws, im, alu, ire, owe};
  endfunction

  task automatic waitReq();
    int n = 0;
    while (imemReq !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (imemReq !== 1'b1) checkOutput("req_wait_timeout", 32'(imemReq), 1);
  endtask

  // Serves one fetch; also raises a stray ack in DECODE that the sequencer must ignore.
  task automatic applyStimulus(input logic [7:0] instr, input logic cond, input logic [7:0] jt,
                               input logic [7:0] expPc, input expT e);
    waitReq();
    checkOutput("fetch_addr", 32'(imemAddr), 32'(expPc));
    expQ.push_back(e);
    imem_ack   = 1'b1;
    imem_data  = instr;
    condTrue   = cond;
    jumpTarget = jt;
    @(negedge clk);
    checkOutput("decode_state", 32'(state), 1);
    imem_data = 8'hFF;
    @(negedge clk);
    imem_ack  = 1'b0;
    imem_data = 8'h00;
  endtask

  initial begin : monitor
    expT e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && state == 2'd2) begin
        if (expQ.size() == 0) begin
          checkOutput("exec_unexpected", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("rf_we",    32'(rfWe),    32'(e.we));
          checkOutput("rf_waddr", 32'(rfWaddr), 32'(e.waddr));
          checkOutput("rf_raddr", 32'(rfRaddr), 32'(e.raddr));
          checkOutput("wsel",     32'(wsel),    32'(e.wsel));
          checkOutput("imm",      32'(imm),     32'(e.imm));
          checkOutput("alu_mode", 32'(aluMode), 32'(e.alu));
          checkOutput("iport_re", 32'(iportRe), 32'(e.ire));
          checkOutput("oport_we", 32'(oportWe), 32'(e.owe));
        end
      end else if ({rfWe, iportRe, oportWe, aluMode} != 6'd0) begin
        strayStrobes++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : driver
    expT none, loadi5;
    none   = '0;
    loadi5 = mkExp(1, 0, 0, 0, 6'd5, 0, 0, 0);
    reset = 1'b0; imem_ack = 1'b0; imem_data = 8'h00; condTrue = 1'b0; jumpTarget = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("reset_state", 32'(state), 0);
    checkOutput("reset_req",   32'(imemReq), 0);
    checkOutput("reset_addr",  32'(imemAddr), 0);
    checkOutput("reset_fault", 32'(fault), 0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("req_after_reset", 32'(imemReq), 1);

    applyStimulus(8'h05, 0, 8'h00, 8'h00, loadi5);
    applyStimulus(8'h05, 0, 8'h00, 8'h01, loadi5);
    applyStimulus(8'h44, 0, 8'h00, 8'h02, mkExp(1, 3, 0, 1, 0, 3'd4, 0, 0));
    applyStimulus(8'hB1, 0, 8'h00, 8'h03, mkExp(1, 1, 0, 3, 0, 0, 1, 0));
    applyStimulus(8'h8E, 0, 8'h00, 8'h04, mkExp(0, 0, 1, 2, 0, 0, 0, 1));
    applyStimulus(8'hBF, 0, 8'h00, 8'h05, none);
    applyStimulus(8'hC4, 1, 8'h20, 8'h06, none);
    applyStimulus(8'hC4, 0, 8'h20, 8'h20, none);
    applyStimulus(8'hC0, 1, 8'hFF, 8'h21, none);
    applyStimulus(8'h05, 1, 8'h77, 8'hFF, loadi5);
    applyStimulus(8'hC0, 1, 8'h00, 8'h00, none);
    applyStimulus(8'h3F, 0, 8'h00, 8'h00, mkExp(1, 0, 0, 0, 6'h3F, 0, 0, 0));
    applyStimulus(8'hB8, 0, 8'h00, 8'h01, none);
    applyStimulus(8'hB6, 0, 8'h00, 8'h02, mkExp(0, 0, 0, 3, 0, 0, 1, 1));

    // Starve the fetch: the 14th missed ack must not fault, the 15th must.
    waitReq();
    checkOutput("timeout_addr", 32'(imemAddr), 3);
    repeat (14) @(negedge clk);
    checkOutput("pre_timeout_state", 32'(state), 0);
    @(negedge clk);
    checkOutput("fault_state", 32'(state), 3);
    checkOutput("fault_flag",  32'(fault), 1);
    checkOutput("fault_req",   32'(imemReq), 0);
    imem_ack  = 1'b1;
    imem_data = 8'h05;
    repeat (3) @(negedge clk);
    checkOutput("fault_sticky_state", 32'(state), 3);
    checkOutput("fault_sticky_flag",  32'(fault), 1);
    checkOutput("fault_no_we",        32'(rfWe), 0);
    imem_ack  = 1'b0;
    imem_data = 8'h00;
    reset = 1'b0;
    #1;
    checkOutput("fault_cleared", 32'(fault), 0);
    checkOutput("fault_reset_state", 32'(state), 0);
    @(negedge clk);
    reset = 1'b1;

    // Asynchronous reset in the middle of the second execute cycle.
    applyStimulus(8'h05, 0, 8'h00, 8'h00, loadi5);
    applyStimulus(8'h05, 0, 8'h00, 8'h01, loadi5);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_rf_we", 32'(rfWe), 0);
    checkOutput("async_imm",   32'(imm), 0);
    checkOutput("async_state", 32'(state), 0);
    checkOutput("async_addr",  32'(imemAddr), 0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(8'h05, 0, 8'h00, 8'h00, loadi5);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drain", 32'(expQ.size()), 0);
    checkOutput("stray_strobes", 32'(strayStrobes), 0);
    $display("%0d/%0d checks passed", passChecks, totalChecks);
    $finish;
  end

endmodule
